// File: rtl/chain_toggle_sequencer_pkg.sv
// Shared types and default sizing for the chain toggle sequencer.
// Holds the FSM state encoding and the default counter width and wait limit.
package chain_toggle_sequencer_pkg;

    localparam int CTS_CNT_W_DEF    = 8;
    localparam int CTS_MAX_WAIT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } cts_state_e;

endpackage

// File: rtl/chain_toggle_sequencer_if.sv
// Control/status bundle of the chain toggle sequencer.
// The master side starts or aborts runs; the slave side reports progress and statistics.
interface chain_toggle_sequencer_if #(
    parameter int CNT_W = chain_toggle_sequencer_pkg::CTS_CNT_W_DEF
);
    logic             start;
    logic             abort;
    logic [7:0]       num_toggles;
    logic             busy;
    logic             done;
    logic             error_timeout;
    logic [CNT_W-1:0] last_latency;
    logic [CNT_W-1:0] max_latency;
    logic [7:0]       toggle_count;

    modport master (
        output start, abort, num_toggles,
        input  busy, done, error_timeout, last_latency, max_latency, toggle_count
    );

    modport slave (
        input  start, abort, num_toggles,
        output busy, done, error_timeout, last_latency, max_latency, toggle_count
    );
endinterface

// File: rtl/chain_toggle_sequencer_sync2.sv
// Two-flop synchronizer bringing the asynchronous chain output into the clk domain.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/chain_toggle_sequencer.sv
// Toggles a delay chain input a programmed number of times, waiting for each
// toggle to propagate and recording per-toggle latency with a timeout guard.
module chain_toggle_sequencer
    import chain_toggle_sequencer_pkg::*;
#(
    parameter bit INVERT   = 1'b1,
    parameter int CNT_W    = CTS_CNT_W_DEF,
    parameter int MAX_WAIT = CTS_MAX_WAIT_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      chain_out,
    output logic                      chain_in,
    chain_toggle_sequencer_if.slave   ctl
);
    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

    cts_state_e       state_q, state_d;
    logic             chain_in_q, chain_in_d;
    logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [7:0]       count_q, count_d;
    logic [7:0]       toggle_count_q, toggle_count_d;
    logic [CNT_W-1:0] last_lat_q, last_lat_d;
    logic [CNT_W-1:0] max_lat_q, max_lat_d;
    logic             err_q, err_d;
    logic             sout;
    logic             match;
    logic             abort_eff;
    logic             last_toggle;
    logic             busy;
    logic             done;

    sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (chain_out),
        .q     (sout)
    );

    // chain_in_q already holds the post-toggle level while waiting
    assign match       = (sout == (chain_in_q ^ INVERT));
    assign abort_eff   = ctl.abort && (state_q != ST_IDLE);
    assign last_toggle = ((toggle_count_q + 8'd1) == count_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ctl.start) state_d = (ctl.num_toggles != 8'd0) ? ST_DRIVE : ST_DONE;
            ST_DRIVE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (match)                        state_d = last_toggle ? ST_DONE : ST_DRIVE;
                else if (lat_cnt_q == MAX_WAIT_C) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (abort_eff) state_d = ST_IDLE;
    end

    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    // An abort freezes every datapath register, including a same-cycle match
    always_comb begin
        chain_in_d     = chain_in_q;
        lat_cnt_d      = lat_cnt_q;
        count_d        = count_q;
        toggle_count_d = toggle_count_q;
        last_lat_d     = last_lat_q;
        max_lat_d      = max_lat_q;
        err_d          = err_q;
        if (!abort_eff) begin
            case (state_q)
                ST_IDLE: begin
                    if (ctl.start) begin
                        count_d        = ctl.num_toggles;
                        toggle_count_d = 8'd0;
                        max_lat_d      = '0;
                        err_d          = 1'b0;
                    end
                end
                ST_DRIVE: begin
                    chain_in_d = ~chain_in_q;
                    lat_cnt_d  = ONE_C;
                end
                ST_WAIT: begin
                    if (match) begin
                        last_lat_d     = lat_cnt_q;
                        toggle_count_d = toggle_count_q + 8'd1;
                        if (lat_cnt_q > max_lat_q) max_lat_d = lat_cnt_q;
                    end else if (lat_cnt_q == MAX_WAIT_C) begin
                        err_d = 1'b1;
                    end else begin
                        lat_cnt_d = lat_cnt_q + ONE_C;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_in_q     <= 1'b0;
            lat_cnt_q      <= '0;
            count_q        <= 8'd0;
            toggle_count_q <= 8'd0;
            last_lat_q     <= '0;
            max_lat_q      <= '0;
            err_q          <= 1'b0;
        end else begin
            chain_in_q     <= chain_in_d;
            lat_cnt_q      <= lat_cnt_d;
            count_q        <= count_d;
            toggle_count_q <= toggle_count_d;
            last_lat_q     <= last_lat_d;
            max_lat_q      <= max_lat_d;
            err_q          <= err_d;
        end
    end

    assign chain_in          = chain_in_q;
    assign ctl.busy          = busy;
    assign ctl.done          = done;
    assign ctl.error_timeout = err_q;
    assign ctl.last_latency  = last_lat_q;
    assign ctl.max_latency   = max_lat_q;
    assign ctl.toggle_count  = toggle_count_q;
endmodule
